inv_stream_controller: RTL and testbench
========================================

# inv_stream_controller

Sequencer between the 3x3 matrix-inversion core and the byte-serial output interface. It accepts matrix requests from upstream and launches the inversion core. It captures each 144-bit inverse result into a 2-entry ping-pong buffer, then feeds buffered results to the serializer one frame at a time. The core can therefore compute matrix N+1 while matrix N is still being shifted out.

## Interface

Parameters:
- DATA_W, 16, width of one inverse element
- TIMEOUT, 1023, max cycles from core_start to core_done (watchdog builds only)
- CNT_W, 8, width of frames_sent counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-low
- req_valid  in  1  upstream has a matrix ready for inversion
- req_ready  out  1  controller can launch the core
- core_start  out  1  one-cycle launch pulse to inversion core
- core_done  in  1  one-cycle pulse; core_result valid in the same cycle
- core_result  in  9*DATA_W  flattened {inv11..inv33}, inv11 in MSBs
- ser_start  out  1  one-cycle start pulse to serializer
- ser_data  out  9*DATA_W  frame for serializer, same packing as core_result
- ser_done  in  1  serializer finished 18 bytes
- frame_done  out  1  one-cycle pulse per completed frame
- frames_sent  out  CNT_W  completed-frame count, wraps
- busy  out  1  any FSM non-idle or buffer non-empty
- err_timeout  out  1  sticky watchdog flag

## Operation

- Core FSM states:
  - C_IDLE: handshake when req_valid & req_ready; go to C_RUN.
  - C_RUN: on core_done, push core_result into the buffer; go to C_IDLE.
- req_ready = rst & (core FSM in C_IDLE) & (count < 2). req_ready is combinational and does not depend on req_valid.
- Result buffer: 2 entries, wr_ptr/rd_ptr 1 bit each, count 0..2. Both pointers wrap 1->0.
  - Push and pop in the same cycle leaves count unchanged.
  - A push never occurs while full; req_ready guarantees this.
- Serializer FSM states:
  - S_IDLE: when count > 0, go to S_START.
  - S_START: ser_start = 1 for one cycle; go to S_WAIT.
  - S_WAIT: on ser_done, pop the head entry, pulse frame_done, increment frames_sent (modulo 2^CNT_W); go to S_IDLE.
- ser_data always shows the buffer head entry. It is stable from S_START until ser_done.
- core_done outside C_RUN is ignored. ser_done outside S_WAIT is ignored.
- Synchronous reset mid-operation abandons all in-flight work:
  - both FSMs go idle; count = 0; pointers = 0; frames_sent = 0; err_timeout = 0.
  - The serializer shares rst and resets in the same cycle.

## Timing

- Reset values of outputs: req_ready 0 (while rst low), core_start 0, ser_start 0, ser_data 0, frame_done 0, frames_sent 0, busy 0, err_timeout 0.
- Handshake sampled at edge N -> core_start high during cycle N+1 only.
- core_done sampled at edge M -> entry stored and count updated at M.
  - If the serializer FSM is idle, ser_start is high during cycle M+2 (S_IDLE -> S_START takes one edge).
- ser_done at edge K -> frame_done high during cycle K+1; frames_sent updated at K.
  - The next ser_start follows no earlier than cycle K+2, which satisfies the serializer's return-to-idle.
- Minimum frame period is serializer-bound (about 20 cycles). Core/serializer overlap is limited by the 2 buffer entries.

## Configuration

- INV_CTRL_TIMEOUT_EN defined:
  - A counter runs in C_RUN.
  - If core_done is not seen within TIMEOUT cycles after core_start, the core FSM aborts to C_IDLE with no push.
  - err_timeout sets and stays set until reset.
  - core_done arriving exactly in cycle TIMEOUT is accepted.
- Undefined: C_RUN waits indefinitely and err_timeout is tied to 0.

## Structure

- Package inv_ctrl_pkg holds:
  - core and serializer state enums (C_IDLE/C_RUN, S_IDLE/S_START/S_WAIT)
  - MAT_W = 9*DATA_W
  - the default TIMEOUT constant
- One sub-module, inv_result_fifo2: 2-entry buffer with push/pop/count/head, reused unchanged elsewhere.
- Everything else lives in inv_stream_controller.

## Test plan

- Single matrix:
  - Stimulus: req_valid pulse; core_done 5 cycles after core_start with result 144'h0001_0002_..._0009; ser_done 19 cycles after ser_start.
  - Expect: exactly one core_start; one ser_start with ser_data = that result; frame_done once; frames_sent = 1; busy drops to 0.
- Back-pressure:
  - Stimulus: req_valid held high, core done in 3 cycles, serializer stalled (ser_done withheld).
  - Expect: two frames buffered; req_ready low with count = 2; no third core_start until the first ser_done.
- Simultaneous push/pop:
  - Stimulus: core_done and ser_done on the same edge with count = 1.
  - Expect: count stays 1; next ser_data = the new result.
- Counter wrap (CNT_W = 8):
  - Stimulus: 257 frames.
  - Expect: frames_sent = 1; frame_done pulses 257 times.
- Reset mid-frame:
  - Stimulus: rst low for 1 cycle during S_WAIT with count = 2.
  - Expect: all outputs at reset values next cycle; subsequent ser_done ignored.
- Watchdog (INV_CTRL_TIMEOUT_EN, TIMEOUT = 8):
  - Stimulus: core_done never arrives.
  - Expect: err_timeout = 1 after 8 cycles; req_ready returns to 1; no push.
  - Same build, core_done at exactly cycle 8: result accepted, err_timeout = 0.

Source files
------------

// File: rtl/inv_ctrl_pkg.sv
// Shared types and constants for the matrix-inversion stream controller.
package inv_ctrl_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned MAT_W       = 9 * DEF_DATA_W;
  localparam int unsigned DEF_TIMEOUT = 1023;

  typedef enum logic {
    C_IDLE,
    C_RUN
  } core_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } ser_state_e;

endpackage

// File: rtl/inv_result_fifo2.sv
// Two-entry ping-pong result buffer; head always shows the oldest entry.
module inv_result_fifo2 import inv_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = MAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  // Overflow/underflow requests are dropped so pointers never desynchronise
  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 2'd1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inv_stream_controller.sv
// Sequencer between the 3x3 inversion core and the byte serializer.
// Results are double-buffered so the core can run one matrix ahead of the output.
// Optional watchdog on core completion: define INV_CTRL_TIMEOUT_EN.
module inv_stream_controller import inv_ctrl_pkg::*; #(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  output logic                core_start,
  input  logic                core_done,
  input  logic [9*DATA_W-1:0] core_result,
  output logic                ser_start,
  output logic [9*DATA_W-1:0] ser_data,
  input  logic                ser_done,
  output logic                frame_done,
  output logic [CNT_W-1:0]    frames_sent,
  output logic                busy,
  output logic                err_timeout
);

  core_state_e      core_state_q;
  ser_state_e       ser_state_q;
  logic             core_start_q;
  logic             ser_start_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] frames_sent_q;
  logic [1:0]       fifo_count;
  logic             handshake;
  logic             push;
  logic             pop;
  logic             timed_out;

  // Only one core job in flight, so a free slot at launch guarantees room for its result
  assign req_ready = rst && (core_state_q == C_IDLE) && (fifo_count < 2'd2);
  assign handshake = req_valid && req_ready;
  assign push      = (core_state_q == C_RUN) && core_done;
  assign pop       = (ser_state_q == S_WAIT) && ser_done;

  inv_result_fifo2 #(
    .WIDTH(9 * DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(core_result),
    .pop_i      (pop),
    .count_o    (fifo_count),
    .head_o     (ser_data)
  );

`ifdef INV_CTRL_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] timer_q;
  logic             err_q;

  // core_done in the cycle where the timer equals TIMEOUT still wins over the abort
  assign timed_out = (core_state_q == C_RUN) && !core_done && (timer_q == TMR_W'(TIMEOUT));

  // Cycles elapsed since core_start, plus the sticky abort flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (handshake) begin
        timer_q <= '0;
      end else if ((core_state_q == C_RUN) && (timer_q != TMR_W'(TIMEOUT))) begin
        timer_q <= timer_q + TMR_W'(1);
      end
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_q;
`else
  assign timed_out   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Core launch FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      core_state_q <= C_IDLE;
      core_start_q <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      unique case (core_state_q)
        C_IDLE: begin
          if (handshake) begin
            core_state_q <= C_RUN;
            core_start_q <= 1'b1;
          end
        end
        C_RUN: begin
          if (push || timed_out) begin
            core_state_q <= C_IDLE;
          end
        end
        default: core_state_q <= C_IDLE;
      endcase
    end
  end

  // Serializer feed FSM; head entry is held until the serializer reports done
  always_ff @(posedge clk) begin
    if (!rst) begin
      ser_state_q   <= S_IDLE;
      ser_start_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      ser_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (ser_state_q)
        S_IDLE: begin
          if (fifo_count != 2'd0) begin
            ser_state_q <= S_START;
            ser_start_q <= 1'b1;
          end
        end
        S_START: ser_state_q <= S_WAIT;
        S_WAIT: begin
          if (pop) begin
            ser_state_q   <= S_IDLE;
            frame_done_q  <= 1'b1;
            frames_sent_q <= frames_sent_q + CNT_W'(1);
          end
        end
        default: ser_state_q <= S_IDLE;
      endcase
    end
  end

  assign core_start  = core_start_q;
  assign ser_start   = ser_start_q;
  assign frame_done  = frame_done_q;
  assign frames_sent = frames_sent_q;
  assign busy        = (core_state_q != C_IDLE) || (ser_state_q != S_IDLE) ||
                       (fifo_count != 2'd0);

endmodule

// File: tb/tb_inv_stream_controller.sv
// Self-checking bench for inv_stream_controller (scoreboard of inverse results).
module tb_inv_stream_controller;

  localparam int unsigned MW = 144;
`ifdef INV_CTRL_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 1023;
`endif

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          core_start;
  logic          core_done;
  logic [MW-1:0] core_result;
  logic          ser_start;
  logic [MW-1:0] ser_data;
  logic          ser_done;
  logic          frame_done;
  logic [7:0]    frames_sent;
  logic          busy;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected results at core_done, observed frames at ser_start
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] obs_q[$];

  int core_start_cnt = 0;
  int ser_start_cnt  = 0;
  int frame_done_cnt = 0;

  bit core_auto = 0;
  int core_lat  = 5;
  bit ser_auto  = 0;
  bit ser_hold  = 0;
  int ser_lat   = 19;
  int res_idx   = 0;

  inv_stream_controller #(
    .DATA_W (16),
    .TIMEOUT(TB_TIMEOUT),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .core_start (core_start),
    .core_done  (core_done),
    .core_result(core_result),
    .ser_start  (ser_start),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .frame_done (frame_done),
    .frames_sent(frames_sent),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [MW-1:0] make_result(int idx);
    logic [MW-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[MW-1-16*k -: 16] = 16'(idx * 9 + k + 1);
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_result();
    return {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
  endfunction

  // Output monitor
  always @(negedge clk) begin
    if (core_start) core_start_cnt++;
    if (ser_start) begin
      ser_start_cnt++;
      obs_q.push_back(ser_data);
    end
    if (frame_done) frame_done_cnt++;
  end

  // Inversion core model: answers core_start after core_lat cycles
  initial begin : core_model
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start && core_auto) begin
        repeat (core_lat) @(negedge clk);
        core_done   = 1'b1;
        core_result = make_result(res_idx);
        exp_q.push_back(core_result);
        res_idx++;
        @(negedge clk);
        core_done = 1'b0;
      end
    end
  end

  // Serializer model: ser_done ser_lat cycles after ser_start, stalled while ser_hold
  initial begin : ser_model
    ser_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ser_start && ser_auto) begin
        repeat (ser_lat) @(negedge clk);
        while (ser_hold) @(negedge clk);
        ser_done = 1'b1;
        @(negedge clk);
        ser_done = 1'b0;
      end
    end
  end

  initial begin : global_guard
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = 1'b0;
    core_done = 1'b0;
    ser_done  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    obs_q.delete();
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = 1'b0;
    tick();
    tick();
    checks += 9;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    if (core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start: got %b want 0", core_start); end
    if (ser_start !== 1'b0) begin errors++; $display("FAIL rst_ser_start: got %b want 0", ser_start); end
    if (ser_data !== '0) begin errors++; $display("FAIL rst_ser_data: got %h want 0", ser_data); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    if (frames_sent !== 8'd0) begin errors++; $display("FAIL rst_frames_sent: got %0d want 0", frames_sent); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    rst = 1'b1;
    tick();
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single();
    int cs0, ss0, fd0, n;
    logic [MW-1:0] want, got, lit;
    do_reset();
    core_auto = 1; core_lat = 5; ser_auto = 1; ser_hold = 0; ser_lat = 19;
    cs0 = core_start_cnt; ss0 = ser_start_cnt; fd0 = frame_done_cnt;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks += 2;
    if (core_start !== 1'b1) begin errors++; $display("FAIL single_core_start: got %b want 1", core_start); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL single_ready_run: got %b want 0", req_ready); end
    n = 0;
    while (frame_done_cnt - fd0 < 1 && n < 100) begin tick(); n++; end
    repeat (3) tick();
    checks += 7;
    if (core_start_cnt - cs0 != 1) begin errors++; $display("FAIL single_core_starts: got %0d want 1", core_start_cnt - cs0); end
    if (ser_start_cnt - ss0 != 1) begin errors++; $display("FAIL single_ser_starts: got %0d want 1", ser_start_cnt - ss0); end
    if (frame_done_cnt - fd0 != 1) begin errors++; $display("FAIL single_frame_done: got %0d want 1", frame_done_cnt - fd0); end
    if (frames_sent !== 8'd1) begin errors++; $display("FAIL single_frames_sent: got %0d want 1", frames_sent); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL single_sb_size: got obs %0d exp %0d want 1/1", obs_q.size(), exp_q.size());
      obs_q.delete(); exp_q.delete();
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      lit = 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009;
      if (got !== want) begin errors++; $display("FAIL single_ser_data: got %h want %h", got, want); end
      checks++;
      if (got !== lit) begin errors++; $display("FAIL single_literal: got %h want %h", got, lit); end
    end
    core_auto = 0; ser_auto = 0;
  endtask

  task automatic test_back_pressure();
    int cs0, ss0, fd0, n;
    logic [MW-1:0] want, got;
    do_reset();
    core_auto = 1; core_lat = 3; ser_auto = 1; ser_hold = 1; ser_lat = 2;
    cs0 = core_start_cnt; ss0 = ser_start_cnt; fd0 = frame_done_cnt;
    req_valid = 1'b1;
    repeat (40) tick();
    checks += 4;
    if (core_start_cnt - cs0 != 2) begin errors++; $display("FAIL bp_core_starts: got %0d want 2", core_start_cnt - cs0); end
    if (dut.fifo_count !== 2'd2) begin errors++; $display("FAIL bp_count: got %0d want 2", dut.fifo_count); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", req_ready); end
    if (ser_start_cnt - ss0 != 1) begin errors++; $display("FAIL bp_ser_starts: got %0d want 1", ser_start_cnt - ss0); end
    ser_hold = 0;
    n = 0;
    while (core_start_cnt - cs0 < 3 && n < 60) begin tick(); n++; end
    req_valid = 1'b0;
    checks += 2;
    if (core_start_cnt - cs0 != 3) begin errors++; $display("FAIL bp_third_start: got %0d want 3", core_start_cnt - cs0); end
    if (frame_done_cnt - fd0 < 1) begin errors++; $display("FAIL bp_start_before_done: got %0d frames want >=1", frame_done_cnt - fd0); end
    n = 0;
    while (frame_done_cnt - fd0 < 3 && n < 200) begin tick(); n++; end
    repeat (3) tick();
    checks++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      errors++;
      $display("FAIL bp_sb_size: got obs %0d exp %0d want 3/3", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL bp_ser_data: got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
    core_auto = 0; ser_auto = 0;
  endtask

  task automatic test_simultaneous();
    logic [MW-1:0] a, b, want, got;
    do_reset();
    core_auto = 0; ser_auto = 0;
    a = rand_result(); b = rand_result();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (core_start !== 1'b1) begin errors++; $display("FAIL sim_core_start: got %b want 1", core_start); end
    core_done = 1'b1; core_result = a; exp_q.push_back(a);
    tick();
    core_done = 1'b0;
    checks += 2;
    if (ser_start !== 1'b0) begin errors++; $display("FAIL sim_ser_start_early: got %b want 0", ser_start); end
    if (dut.fifo_count !== 2'd1) begin errors++; $display("FAIL sim_count_a: got %0d want 1", dut.fifo_count); end
    tick();
    checks += 2;
    if (ser_start !== 1'b1) begin errors++; $display("FAIL sim_ser_start_m2: got %b want 1", ser_start); end
    if (ser_data !== a) begin errors++; $display("FAIL sim_ser_data_a: got %h want %h", ser_data, a); end
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    core_done = 1'b1; core_result = b; exp_q.push_back(b);
    ser_done  = 1'b1;
    tick();
    core_done = 1'b0; ser_done = 1'b0;
    checks += 5;
    if (dut.fifo_count !== 2'd1) begin errors++; $display("FAIL sim_count_same: got %0d want 1", dut.fifo_count); end
    if (ser_data !== b) begin errors++; $display("FAIL sim_head_b: got %h want %h", ser_data, b); end
    if (frame_done !== 1'b1) begin errors++; $display("FAIL sim_frame_done: got %b want 1", frame_done); end
    if (ser_start !== 1'b0) begin errors++; $display("FAIL sim_ser_start_k1: got %b want 0", ser_start); end
    if (frames_sent !== 8'd1) begin errors++; $display("FAIL sim_frames_sent1: got %0d want 1", frames_sent); end
    tick();
    checks++;
    if (ser_start !== 1'b1) begin errors++; $display("FAIL sim_ser_start_k2: got %b want 1", ser_start); end
    tick();
    ser_done = 1'b1;
    tick();
    ser_done = 1'b0;
    checks += 2;
    if (frames_sent !== 8'd2) begin errors++; $display("FAIL sim_frames_sent2: got %0d want 2", frames_sent); end
    if (dut.fifo_count !== 2'd0) begin errors++; $display("FAIL sim_count_empty: got %0d want 0", dut.fifo_count); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL sim_sb: got %h want %h", got, want); end
    end
    // Stray completions while idle must be ignored
    repeat (3) tick();
    core_done = 1'b1; core_result = rand_result(); ser_done = 1'b1;
    tick();
    core_done = 1'b0; ser_done = 1'b0;
    repeat (3) tick();
    checks += 3;
    if (dut.fifo_count !== 2'd0) begin errors++; $display("FAIL stray_count: got %0d want 0", dut.fifo_count); end
    if (frames_sent !== 8'd2) begin errors++; $display("FAIL stray_frames: got %0d want 2", frames_sent); end
    if (busy !== 1'b0) begin errors++; $display("FAIL stray_busy: got %b want 0", busy); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    int cs0, fd0, n;
    logic [MW-1:0] want, got;
    do_reset();
    core_auto = 1; core_lat = 1; ser_auto = 1; ser_hold = 0; ser_lat = 1;
    cs0 = core_start_cnt; fd0 = frame_done_cnt;
    req_valid = 1'b1;
    n = 0;
    while (frame_done_cnt - fd0 < 257 && n < 6000) begin
      tick();
      if (core_start_cnt - cs0 >= 257) req_valid = 1'b0;
      n++;
    end
    req_valid = 1'b0;
    repeat (5) tick();
    checks += 3;
    if (frame_done_cnt - fd0 != 257) begin errors++; $display("FAIL wrap_frame_done: got %0d want 257", frame_done_cnt - fd0); end
    if (frames_sent !== 8'd1) begin errors++; $display("FAIL wrap_frames_sent: got %0d want 1", frames_sent); end
    if (obs_q.size() != 257 || exp_q.size() != 257) begin
      errors++;
      $display("FAIL wrap_sb_size: got obs %0d exp %0d want 257", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL wrap_ser_data: got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
    core_auto = 0;
  endtask

  task automatic test_reset_mid_frame();
    int cs0, ss0, fd0, n;
    // No do_reset here: frames_sent still holds the previous run's count
    core_auto = 1; core_lat = 3; ser_auto = 1; ser_hold = 1; ser_lat = 2;
    cs0 = core_start_cnt; ss0 = ser_start_cnt; fd0 = frame_done_cnt;
    req_valid = 1'b1;
    n = 0;
    while (core_start_cnt - cs0 < 2 && n < 40) begin tick(); n++; end
    req_valid = 1'b0;
    repeat (15) tick();
    checks += 2;
    if (dut.fifo_count !== 2'd2) begin errors++; $display("FAIL mid_pre_count: got %0d want 2", dut.fifo_count); end
    if (frames_sent === 8'd0) begin errors++; $display("FAIL mid_pre_frames: got 0 want nonzero"); end
    rst = 1'b0;
    tick();
    checks += 8;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_req_ready: got %b want 0", req_ready); end
    if (core_start !== 1'b0) begin errors++; $display("FAIL mid_core_start: got %b want 0", core_start); end
    if (ser_start !== 1'b0) begin errors++; $display("FAIL mid_ser_start: got %b want 0", ser_start); end
    if (ser_data !== '0) begin errors++; $display("FAIL mid_ser_data: got %h want 0", ser_data); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_frame_done: got %b want 0", frame_done); end
    if (frames_sent !== 8'd0) begin errors++; $display("FAIL mid_frames_sent: got %0d want 0", frames_sent); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", err_timeout); end
    rst = 1'b1;
    ser_hold = 0;
    repeat (10) tick();
    checks += 4;
    if (frame_done_cnt - fd0 != 0) begin errors++; $display("FAIL mid_stray_done: got %0d frames want 0", frame_done_cnt - fd0); end
    if (frames_sent !== 8'd0) begin errors++; $display("FAIL mid_frames_after: got %0d want 0", frames_sent); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b want 0", busy); end
    if (ser_start_cnt - ss0 != 1) begin errors++; $display("FAIL mid_ser_starts: got %0d want 1", ser_start_cnt - ss0); end
    obs_q.delete(); exp_q.delete();
    core_auto = 0; ser_auto = 0;
  endtask

`ifdef INV_CTRL_TIMEOUT_EN
  task automatic test_watchdog();
    int fd0, n;
    logic [MW-1:0] d, got;
    do_reset();
    core_auto = 0; ser_auto = 1; ser_hold = 0; ser_lat = 2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (8) tick();
    checks += 2;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL wd_err_early: got %b want 0", err_timeout); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL wd_ready_early: got %b want 0", req_ready); end
    tick();
    checks += 3;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL wd_err_set: got %b want 1", err_timeout); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wd_ready_back: got %b want 1", req_ready); end
    if (dut.fifo_count !== 2'd0) begin errors++; $display("FAIL wd_no_push: got %0d want 0", dut.fifo_count); end
    repeat (5) tick();
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL wd_err_sticky: got %b want 1", err_timeout); end
    // Completion exactly at the limit is accepted
    do_reset();
    fd0 = frame_done_cnt;
    d = rand_result();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (8) tick();
    core_done = 1'b1; core_result = d; exp_q.push_back(d);
    tick();
    core_done = 1'b0;
    checks += 2;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL wd_edge_err: got %b want 0", err_timeout); end
    if (dut.fifo_count !== 2'd1) begin errors++; $display("FAIL wd_edge_push: got %0d want 1", dut.fifo_count); end
    n = 0;
    while (frame_done_cnt - fd0 < 1 && n < 50) begin tick(); n++; end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL wd_edge_frame: got %0d frames want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      checks++;
      if (got !== d) begin errors++; $display("FAIL wd_edge_data: got %h want %h", got, d); end
    end
    obs_q.delete(); exp_q.delete();
    ser_auto = 0;
  endtask
`else
  task automatic test_watchdog();
    int fd0, n;
    logic [MW-1:0] d, got;
    do_reset();
    core_auto = 0; ser_auto = 1; ser_hold = 0; ser_lat = 2;
    fd0 = frame_done_cnt;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (30) tick();
    checks += 3;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL nowd_err: got %b want 0", err_timeout); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL nowd_ready: got %b want 0", req_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL nowd_busy: got %b want 1", busy); end
    d = rand_result();
    core_done = 1'b1; core_result = d; exp_q.push_back(d);
    tick();
    core_done = 1'b0;
    n = 0;
    while (frame_done_cnt - fd0 < 1 && n < 50) begin tick(); n++; end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL nowd_frame: got %0d frames want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      checks++;
      if (got !== d) begin errors++; $display("FAIL nowd_data: got %h want %h", got, d); end
    end
    obs_q.delete(); exp_q.delete();
    ser_auto = 0;
  endtask
`endif

  initial begin : main
    rst       = 1'b0;
    req_valid = 1'b0;
    test_reset();
    test_single();
    test_back_pressure();
    test_simultaneous();
    test_wrap();
    test_reset_mid_frame();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
